demux_scheduler: RTL and testbench

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_rr_next.sv | 26 ++
 rtl/demux_scheduler.sv | 88 ++++++++
 tb/tb_demux_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the single-bit demux scheduler.
package demux_pkg;
    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;
endpackage

// File: rtl/demux_rr_next.sv
// Cyclic search for the first enabled channel starting at start (inclusive) or start+1.
module demux_rr_next
    import demux_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] start,
    input  logic             inclusive,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] cand;

    // Scan from the far end back so the nearest enabled channel wins.
    always_comb begin
        idx   = start;
        found = 1'b0;
        cand  = start;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = start + (inclusive ? SEL_W'(0) : SEL_W'(1)) + SEL_W'(k);
            if (mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_scheduler.sv
// Round-robin demux: steers one accepted bit to the selected enabled channel and
// holds it for HOLD_CYCLES cycles before moving to the next enabled channel.
module demux_scheduler
    import demux_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             N_RESET,
    input  logic             D,
    input  logic             VALID,
    output logic             READY,
    input  logic [N_CH-1:0]  EN_MASK,
    output logic [N_CH-1:0]  Y,
    output logic [N_CH-1:0]  STROBE,
    output logic [SEL_W-1:0] SEL,
    output state_e           STATE_DBG
);
    // Handshake: a bit transfers on a rising edge where VALID && READY; READY is
    // combinational from the registered state and the live EN_MASK, VALID is ignored otherwise.
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [N_CH-1:0]  y_q;
    logic [N_CH-1:0]  strobe_q;
    logic [SEL_W-1:0] nxt_idx;
    logic             nxt_found;

    demux_rr_next u_rr_next (
        .mask      (EN_MASK),
        .start     (sel_q),
        .inclusive (state_q == IDLE),
        .idx       (nxt_idx),
        .found     (nxt_found)
    );

    assign READY     = (state_q == WAIT) && EN_MASK[sel_q];
    assign Y         = y_q;
    assign STROBE    = strobe_q;
    assign SEL       = sel_q;
    assign STATE_DBG = state_q;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            y_q      <= '0;
            strobe_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (nxt_found) begin
                        state_q <= WAIT;
                        sel_q   <= nxt_idx;
                    end
                end
                WAIT: begin
                    if (VALID && READY) begin
                        state_q  <= HOLD;
                        y_q      <= {{(N_CH-1){1'b0}}, D} << sel_q;
                        strobe_q <= {{(N_CH-1){1'b0}}, 1'b1} << sel_q;
                        cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
                    end else if (!EN_MASK[sel_q]) begin
                        if (nxt_found) sel_q <= nxt_idx;
                        else           state_q <= IDLE;
                    end
                end
                HOLD: begin
                    // Mask is only consulted once the hold has run out.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        y_q      <= '0;
                        strobe_q <= '0;
                        if (nxt_found) begin
                            state_q <= WAIT;
                            sel_q   <= nxt_idx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_demux_scheduler.sv
// Random and directed stimulus for two scheduler instances (hold 1 and 3) against a cycle-level reference model.
module tb_demux_scheduler;
  import demux_pkg::*;

  logic       clk;
  logic       n_reset;
  logic       d;
  logic       valid;
  logic [7:0] en_mask;

  logic       ready1, ready3;
  logic [7:0] y1, y3, st1, st3;
  logic [2:0] sel1, sel3;
  state_e     s1, s3;

  int n_checks = 0;
  int n_errors = 0;

  // reference model, index 0 = hold 1, index 1 = hold 3
  int         hv[2] = '{1, 3};
  bit         m_act[2];
  int         m_left[2];
  int         m_sel[2];
  logic [7:0] m_y[2];
  logic [7:0] m_st[2];

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         collect;
  int         y3_hits;

  demux_scheduler #(.HOLD_CYCLES(1)) dut1 (
    .CLK(clk), .N_RESET(n_reset), .D(d), .VALID(valid), .READY(ready1),
    .EN_MASK(en_mask), .Y(y1), .STROBE(st1), .SEL(sel1), .STATE_DBG(s1)
  );

  demux_scheduler #(.HOLD_CYCLES(3)) dut3 (
    .CLK(clk), .N_RESET(n_reset), .D(d), .VALID(valid), .READY(ready3),
    .EN_MASK(en_mask), .Y(y3), .STROBE(st3), .SEL(sel3), .STATE_DBG(s3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [7:0] m, input int start);
    for (int k = 0; k < 8; k++)
      if (m[(start + k) % 8]) return (start + k) % 8;
    return start % 8;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_left[i] = 0; m_sel[i] = 0; m_y[i] = 8'h00; m_st[i] = 8'h00;
    end
  endtask

  function automatic logic exp_ready(input int i);
    return m_act[i] && (m_left[i] == 0) && en_mask[m_sel[i]];
  endfunction

  function automatic state_e exp_state(input int i);
    if (m_left[i] > 0) return HOLD;
    if (m_act[i])      return WAIT;
    return IDLE;
  endfunction

  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      if (m_left[i] > 0) begin
        if (m_left[i] > 1) m_left[i]--;
        else begin
          m_left[i] = 0; m_y[i] = 8'h00; m_st[i] = 8'h00;
          if (en_mask == 8'h00) m_act[i] = 0;
          else m_sel[i] = search(en_mask, m_sel[i] + 1);
        end
      end else if (!m_act[i]) begin
        if (en_mask != 8'h00) begin
          m_act[i] = 1; m_sel[i] = search(en_mask, m_sel[i]);
        end
      end else if (valid && en_mask[m_sel[i]]) begin
        m_left[i] = hv[i];
        m_y[i]    = {7'd0, d} << m_sel[i];
        m_st[i]   = 8'h01 << m_sel[i];
      end else if (!en_mask[m_sel[i]]) begin
        if (en_mask == 8'h00) m_act[i] = 0;
        else m_sel[i] = search(en_mask, m_sel[i] + 1);
      end
    end
  endtask

  task automatic check_all();
    check("ready_h1",  32'(ready1), 32'(exp_ready(0)));
    check("y_h1",      32'(y1),     32'(m_y[0]));
    check("strobe_h1", 32'(st1),    32'(m_st[0]));
    check("sel_h1",    32'(sel1),   32'(m_sel[0]));
    check("state_h1",  32'(s1),     32'(exp_state(0)));
    check("ready_h3",  32'(ready3), 32'(exp_ready(1)));
    check("y_h3",      32'(y3),     32'(m_y[1]));
    check("strobe_h3", 32'(st3),    32'(m_st[1]));
    check("sel_h3",    32'(sel3),   32'(m_sel[1]));
    check("state_h3",  32'(s3),     32'(exp_state(1)));
  endtask

  // driver: inputs are set at the negedge; outputs are checked 1 time unit later
  task automatic tick();
    #1;
    check_all();
    if (collect && st1 != 8'h00) got_q.push_back(st1);
    if (y3 == 8'h10) y3_hits++;
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    #1;
    model_reset();
    check("rst_y_h3",      32'(y3),   32'h00);
    check("rst_strobe_h3", 32'(st3),  32'h00);
    check("rst_sel_h3",    32'(sel3), 32'h0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic compare_seq(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
      else check({tag, "_missing"}, 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  initial begin
    n_reset = 1'b0; d = 1'b0; valid = 1'b0; en_mask = 8'h00;
    collect = 0; y3_hits = 0;
    @(negedge clk);
    apply_reset();

    // all channels enabled, one bit every two cycles on the hold-1 instance
    en_mask = 8'hFF; valid = 1'b1; d = 1'b1;
    collect = 1; got_q.delete();
    repeat (22) tick();
    collect = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
    exp_q.push_back(8'h01);
    compare_seq("seq_ff", 9);

    // sparse mask
    apply_reset();
    en_mask = 8'b1010_0100; valid = 1'b1; d = 1'b1;
    collect = 1; got_q.delete();
    repeat (10) tick();
    collect = 0;
    exp_q.delete();
    exp_q.push_back(8'h04); exp_q.push_back(8'h20); exp_q.push_back(8'h80); exp_q.push_back(8'h04);
    compare_seq("seq_a4", 4);

    // single accept at channel 4 with hold 3
    apply_reset();
    en_mask = 8'h10; valid = 1'b1; d = 1'b1; y3_hits = 0;
    repeat (2) tick();
    valid = 1'b0;
    repeat (6) tick();
    check("hold3_len", 32'(y3_hits), 32'd3);

    // empty mask stays idle, then one channel appears
    apply_reset();
    en_mask = 8'h00; valid = 1'b1;
    repeat (6) tick();
    en_mask = 8'h08; valid = 1'b0;
    repeat (2) tick();
    check("m08_ready", 32'(ready1), 32'd1);
    check("m08_sel",   32'(sel1),   32'd3);

    // drop the waiting channel from the mask
    apply_reset();
    en_mask = 8'h20; valid = 1'b0;
    repeat (2) tick();
    en_mask = 8'h21;
    tick();
    en_mask = 8'h01;
    #1;
    check("drop_ready", 32'(ready1), 32'd0);
    tick();
    check("drop_sel", 32'(sel1), 32'd0);
    en_mask = 8'h00;
    repeat (3) tick();

    // asynchronous reset in the middle of a hold
    apply_reset();
    en_mask = 8'h40; valid = 1'b1; d = 1'b1;
    repeat (3) tick();
    #1;
    check("pre_rst_y_h3", 32'(y3), 32'h40);
    apply_reset();
    valid = 1'b0;
    repeat (2) tick();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      if ($urandom_range(0, 7) == 0)
        en_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      valid = ($urandom_range(0, 3) != 0);
      d     = 1'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
